// File: rtl/axi_tlp_encoder.sv
// -----------------------------------------------------------------------------
// axi_tlp_encoder
// TX completion encoder. Accepts one completion request at a time from the
// decoder, waits for read data when a CplD is needed (or gives up after
// TIMEOUT cycles and sends a Completer-Abort Cpl), then emits a 3DW Cpl/CplD
// TLP as two 64-bit beats on the AXI4-Stream TX interface.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   lnk_up                link up; low flushes the block back to IDLE
//   req_compl             completion request (taken when tlp_enc_ready=1)
//   req_compl_w_data      request needs read data (CplD)
//   compl_code            completion status (SC/UR/CA)
//   tenc_tc/attr/len      traffic class, attributes, length (DW) of request
//   tenc_rid/tag          requester ID and tag
//   tenc_be               {last_be, first_be}
//   tenc_addr             request byte address (lower address source)
//   completer_id          {bus, dev, func} of this endpoint
//   rd_data/rd_data_valid read data and its one-cycle strobe
//   tlp_enc_ready         encoder idle and able to accept a request
//   tx_tvalid/tready/tdata/tstrb/tlast   AXI4-Stream TX master
// -----------------------------------------------------------------------------
module axi_tlp_encoder #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lnk_up,
  input  logic        req_compl,
  input  logic        req_compl_w_data,
  input  logic [2:0]  compl_code,
  input  logic [2:0]  tenc_tc,
  input  logic [1:0]  tenc_attr,
  input  logic [9:0]  tenc_len,
  input  logic [15:0] tenc_rid,
  input  logic [7:0]  tenc_tag,
  input  logic [7:0]  tenc_be,
  input  logic [12:0] tenc_addr,
  input  logic [15:0] completer_id,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid,
  output logic        tlp_enc_ready,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tstrb,
  output logic        tx_tlast
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    HDR       = 2'd2,
    DATA      = 2'd3
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic           with_data_r;
  logic [2:0]     tc_r;
  logic [1:0]     attr_r;
  logic [9:0]     len_r;
  logic [15:0]    rid_r;
  logic [7:0]     tag_r;
  logic [3:0]     first_be_r;
  logic [4:0]     addr_r;      // tenc_addr[6:2]; the low bits come from first_be
  logic [31:0]    rd_data_r;

  // last_be and the address bits outside [6:2] play no part in a 3DW completion
  logic unused_s;
  assign unused_s = ^{tenc_be[7:4], tenc_addr[12:7], tenc_addr[1:0]};

  // Byte count: single-DW requests span first_be; longer ones are len*4 (mod 4096).
  // len==0 means 1024 DW, which wraps the 12-bit count to 0.
  function automatic logic [11:0] byte_count(input logic [3:0] first_be,
                                             input logic [9:0] len);
    logic [11:0] bc;
    if (len != 10'd1) begin
      bc = {len, 2'b00};
    end else begin
      casez (first_be)
        4'b1??1:                   bc = 12'd4;
        4'b01?1, 4'b1?10:          bc = 12'd3;
        4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
        default:                   bc = 12'd1;
      endcase
    end
    return bc;
  endfunction

  // Byte offset of the first enabled byte within the DW
  function automatic logic [1:0] lower_off(input logic [3:0] first_be);
    logic [1:0] off;
    casez (first_be)
      4'b???1: off = 2'b00;
      4'b??10: off = 2'b01;
      4'b?100: off = 2'b10;
      4'b1000: off = 2'b11;
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  // Header beat: DW0 (fmt/type/tc/attr/len) in [31:0], DW1 (completer/status/count) in [63:32]
  function automatic logic [63:0] hdr_beat(input logic        with_data,
                                           input logic [2:0]  status,
                                           input logic [2:0]  tc,
                                           input logic [1:0]  attr,
                                           input logic [9:0]  len,
                                           input logic [3:0]  first_be,
                                           input logic [15:0] cid);
    logic [1:0]  fmt;
    logic [9:0]  len_f;
    logic [31:0] dw0;
    logic [31:0] dw1;
    fmt   = with_data ? 2'b10 : 2'b00;
    len_f = with_data ? len : 10'd0;
    dw0   = {1'b0, fmt, 5'b01010, 1'b0, tc, 4'b0000, 2'b00, attr, 2'b00, len_f};
    dw1   = {cid, status, 1'b0, byte_count(first_be, len)};
    return {dw1, dw0};
  endfunction

  // Second beat: DW2 (requester/tag/lower address) in [31:0], payload DW in [63:32]
  function automatic logic [63:0] data_beat(input logic        with_data,
                                            input logic [15:0] rid,
                                            input logic [7:0]  tag,
                                            input logic [4:0]  addr_hi,
                                            input logic [3:0]  first_be,
                                            input logic [31:0] data);
    logic [31:0] dw0;
    logic [31:0] dw1;
    dw0 = {rid, tag, 1'b0, addr_hi, lower_off(first_be)};
    dw1 = with_data ? data : 32'h0000_0000;
    return {dw1, dw0};
  endfunction

  // Ready is only meaningful while idle and out of reset with the link up
  assign tlp_enc_ready = (state_r == IDLE) & lnk_up & reset;

  // Request sequencing FSM with registered AXI-S outputs
  always_ff @(posedge clk) begin
    if (!reset || !lnk_up) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      with_data_r <= 1'b0;
      tc_r        <= 3'd0;
      attr_r      <= 2'd0;
      len_r       <= 10'd0;
      rid_r       <= 16'd0;
      tag_r       <= 8'd0;
      first_be_r  <= 4'd0;
      addr_r      <= 5'd0;
      rd_data_r   <= 32'd0;
      tx_tvalid   <= 1'b0;
      tx_tlast    <= 1'b0;
      tx_tdata    <= 64'd0;
      tx_tstrb    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_compl) begin
            tc_r        <= tenc_tc;
            attr_r      <= tenc_attr;
            len_r       <= tenc_len;
            rid_r       <= tenc_rid;
            tag_r       <= tenc_tag;
            first_be_r  <= tenc_be[3:0];
            addr_r      <= tenc_addr[6:2];
            with_data_r <= req_compl_w_data;
            cnt_r       <= '0;
            if (req_compl_w_data) begin
              state_r <= WAIT_DATA;
            end else begin
              // Cpl needs nothing further: present the header straight away
              state_r   <= HDR;
              tx_tvalid <= 1'b1;
              tx_tlast  <= 1'b0;
              tx_tstrb  <= 8'hFF;
              tx_tdata  <= hdr_beat(1'b0, compl_code, tenc_tc, tenc_attr,
                                    tenc_len, tenc_be[3:0], completer_id);
            end
          end
        end

        WAIT_DATA: begin
          // Data arriving on the timeout edge still wins
          if (rd_data_valid) begin
            rd_data_r <= rd_data;
            state_r   <= HDR;
            tx_tvalid <= 1'b1;
            tx_tlast  <= 1'b0;
            tx_tstrb  <= 8'hFF;
            tx_tdata  <= hdr_beat(1'b1, compl_code, tc_r, attr_r, len_r,
                                  first_be_r, completer_id);
          end else if (cnt_r == TIMEOUT_C) begin
            // Give up: report Completer Abort as a data-less Cpl
            with_data_r <= 1'b0;
            state_r     <= HDR;
            tx_tvalid   <= 1'b1;
            tx_tlast    <= 1'b0;
            tx_tstrb    <= 8'hFF;
            tx_tdata    <= hdr_beat(1'b0, 3'b100, tc_r, attr_r, len_r,
                                    first_be_r, completer_id);
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end

        HDR: begin
          if (tx_tready) begin
            state_r  <= DATA;
            tx_tlast <= 1'b1;
            tx_tstrb <= with_data_r ? 8'hFF : 8'h0F;
            tx_tdata <= data_beat(with_data_r, rid_r, tag_r, addr_r,
                                  first_be_r, rd_data_r);
          end
        end

        DATA: begin
          if (tx_tready) begin
            state_r   <= IDLE;
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
            tx_tstrb  <= 8'd0;
            tx_tdata  <= 64'd0;
          end
        end

        default: begin
          state_r   <= IDLE;
          tx_tvalid <= 1'b0;
          tx_tlast  <= 1'b0;
          tx_tstrb  <= 8'd0;
          tx_tdata  <= 64'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_tlp_encoder.sv
module tb_axi_tlp_encoder;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        lnk_up;
  logic        req_compl;
  logic        req_compl_w_data;
  logic [2:0]  compl_code;
  logic [2:0]  tenc_tc;
  logic [1:0]  tenc_attr;
  logic [9:0]  tenc_len;
  logic [15:0] tenc_rid;
  logic [7:0]  tenc_tag;
  logic [7:0]  tenc_be;
  logic [12:0] tenc_addr;
  logic [15:0] completer_id;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        tlp_enc_ready;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tstrb;
  logic        tx_tlast;

  int n_checks = 0;
  int n_fail   = 0;

  axi_tlp_encoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .lnk_up(lnk_up),
    .req_compl(req_compl), .req_compl_w_data(req_compl_w_data),
    .compl_code(compl_code), .tenc_tc(tenc_tc), .tenc_attr(tenc_attr),
    .tenc_len(tenc_len), .tenc_rid(tenc_rid), .tenc_tag(tenc_tag),
    .tenc_be(tenc_be), .tenc_addr(tenc_addr), .completer_id(completer_id),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .tlp_enc_ready(tlp_enc_ready), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tdata(tx_tdata), .tx_tstrb(tx_tstrb), .tx_tlast(tx_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: expected two beats of a completion, derived from the TLP rules
  function automatic void model(input logic w, input logic [2:0] st,
                                input logic [2:0] tc, input logic [1:0] attr,
                                input logic [9:0] len, input logic [15:0] cid,
                                input logic [15:0] rid, input logic [7:0] tag,
                                input logic [7:0] be, input logic [12:0] addr,
                                input logic [31:0] data,
                                output logic [63:0] b0, output logic [63:0] b1,
                                output logic [7:0] s1);
    int lo, hi, bytes, lower;
    longint dw0, dw1, dw2, dw3;
    lo = -1; hi = -1;
    for (int i = 0; i < 4; i++) if (be[i]) begin if (lo < 0) lo = i; hi = i; end
    bytes = (lo < 0) ? 1 : hi - lo + 1;
    if (len != 10'd1) bytes = (int'(len) * 4) % 4096;
    lower = (int'(addr) % 128) / 4 * 4 + ((lo < 0) ? 0 : lo);
    dw0 = (w ? 2 : 0) * 64'd536870912 + 10 * 64'd16777216 + int'(tc) * 64'd1048576
          + int'(attr) * 64'd4096 + (w ? int'(len) : 0);
    dw1 = int'(cid) * 64'd65536 + int'(st) * 64'd8192 + bytes;
    dw2 = int'(rid) * 64'd65536 + int'(tag) * 64'd256 + lower;
    dw3 = w ? longint'(data) : 64'd0;
    b0 = 64'(dw1 * 64'd4294967296 + dw0);
    b1 = 64'(dw3 * 64'd4294967296 + dw2);
    s1 = w ? 8'hFF : 8'h0F;
  endfunction

  task automatic beat(input string nm, input logic [63:0] d, input logic [7:0] s,
                      input logic l, input int stall);
    chk({nm, " tvalid"}, 64'(tx_tvalid), 64'd1);
    chk({nm, " tdata"}, tx_tdata, d);
    chk({nm, " tstrb"}, 64'(tx_tstrb), 64'(s));
    chk({nm, " tlast"}, 64'(tx_tlast), 64'(l));
    for (int i = 0; i < stall; i++) begin
      tx_tready = 1'b0;
      @(negedge clk);
      chk({nm, " stall tvalid"}, 64'(tx_tvalid), 64'd1);
      chk({nm, " stall tdata"}, tx_tdata, d);
    end
    tx_tready = 1'b1;
    @(negedge clk);
    tx_tready = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int g = 0;
    while (!tlp_enc_ready && g < 20) begin @(negedge clk); g++; end
    chk({nm, " ready"}, 64'(tlp_enc_ready), 64'd1);
  endtask

  task automatic drive_req(input logic wd, input logic [2:0] code, input logic [2:0] tc,
                           input logic [1:0] attr, input logic [9:0] len,
                           input logic [15:0] rid, input logic [7:0] tag,
                           input logic [7:0] be, input logic [12:0] addr);
    req_compl = 1'b1; req_compl_w_data = wd; compl_code = code;
    tenc_tc = tc; tenc_attr = attr; tenc_len = len; tenc_rid = rid;
    tenc_tag = tag; tenc_be = be; tenc_addr = addr;
    @(negedge clk);
    req_compl = 1'b0; req_compl_w_data = 1'($urandom);
    // fields are don't-care after accept
    tenc_tc = 3'($urandom); tenc_attr = 2'($urandom); tenc_len = 10'($urandom);
    tenc_rid = 16'($urandom); tenc_tag = 8'($urandom); tenc_be = 8'($urandom);
    tenc_addr = 13'($urandom);
  endtask

  // delay < 0: never supply data (timeout path)
  task automatic run_req(input string nm, input logic wd, input logic [2:0] code,
                         input logic [2:0] tc, input logic [1:0] attr, input logic [9:0] len,
                         input logic [15:0] rid, input logic [7:0] tag, input logic [7:0] be,
                         input logic [12:0] addr, input logic [31:0] data,
                         input int delay, input int stall);
    logic [63:0] b0, b1;
    logic [7:0]  s1;
    logic        eff_w;
    logic [2:0]  st;
    int          cnt;
    wait_ready(nm);
    drive_req(wd, code, tc, attr, len, rid, tag, be, addr);
    chk({nm, " busy"}, 64'(tlp_enc_ready), 64'd0);
    eff_w = 1'b0; st = code;
    if (wd) begin
      if (delay >= 0) begin
        repeat (delay) @(negedge clk);
        chk({nm, " no early tvalid"}, 64'(tx_tvalid), 64'd0);
        rd_data_valid = 1'b1; rd_data = data;
        @(negedge clk);
        rd_data_valid = 1'b0; rd_data = $urandom;
        eff_w = 1'b1;
      end else begin
        cnt = 0;
        while (!tx_tvalid && cnt < 400) begin @(negedge clk); cnt++; end
        chk({nm, " timeout cycles"}, 64'(cnt), 64'(TIMEOUT + 1));
        st = 3'b100;
      end
    end
    model(eff_w, st, tc, attr, len, completer_id, rid, tag, be, addr, data, b0, b1, s1);
    beat({nm, " hdr"}, b0, 8'hFF, 1'b0, stall);
    beat({nm, " data"}, b1, s1, 1'b1, stall);
    chk({nm, " idle tvalid"}, 64'(tx_tvalid), 64'd0);
    chk({nm, " ready back"}, 64'(tlp_enc_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " tvalid"}, 64'(tx_tvalid), 64'd0);
    chk({nm, " tlast"}, 64'(tx_tlast), 64'd0);
    chk({nm, " tdata"}, tx_tdata, 64'd0);
    chk({nm, " tstrb"}, 64'(tx_tstrb), 64'd0);
    chk({nm, " ready"}, 64'(tlp_enc_ready), 64'd0);
  endtask

  initial begin
    reset = 1'b0; lnk_up = 1'b1; req_compl = 1'b0; req_compl_w_data = 1'b0;
    compl_code = 3'd0; tenc_tc = 3'd0; tenc_attr = 2'd0; tenc_len = 10'd1;
    tenc_rid = 16'd0; tenc_tag = 8'd0; tenc_be = 8'd0; tenc_addr = 13'd0;
    completer_id = 16'h0100; rd_data = 32'd0; rd_data_valid = 1'b0; tx_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("ready after reset", 64'(tlp_enc_ready), 64'd1);

    // Stray read data while idle must be ignored
    rd_data_valid = 1'b1; rd_data = 32'h1234_5678;
    @(negedge clk);
    rd_data_valid = 1'b0;
    chk("idle rd_data ignored", 64'(tx_tvalid), 64'd0);

    run_req("cpld", 1'b1, 3'b000, 3'd0, 2'd0, 10'd1, 16'h01a0, 8'h09, 8'h0F,
            13'h0010, 32'hdeadbeef, 5, 0);
    run_req("cpl_ur", 1'b0, 3'b001, 3'd0, 2'd0, 10'd1, 16'h01a0, 8'h0b, 8'h01,
            13'h0000, 32'h0, 0, 0);
    run_req("stall", 1'b1, 3'b000, 3'd5, 2'd2, 10'd1, 16'hbeef, 8'h77, 8'hF6,
            13'h1f4d, 32'hcafef00d, 2, 3);
    run_req("timeout", 1'b1, 3'b000, 3'd0, 2'd0, 10'd1, 16'h01a0, 8'h10, 8'h0F,
            13'h0000, 32'h0, -1, 0);
    run_req("data_at_timeout", 1'b1, 3'b000, 3'd1, 2'd1, 10'd1, 16'h0042, 8'h11,
            8'h03, 13'h0004, 32'h0badf00d, TIMEOUT, 1);
    run_req("be0c", 1'b1, 3'b000, 3'd0, 2'd0, 10'd1, 16'h01a0, 8'h20, 8'h0C,
            13'h0012, 32'h11112222, 0, 0);
    run_req("be08", 1'b0, 3'b000, 3'd0, 2'd0, 10'd1, 16'h01a0, 8'h21, 8'h08,
            13'h0012, 32'h0, 0, 0);
    run_req("len4", 1'b1, 3'b000, 3'd7, 2'd3, 10'd4, 16'h0a0b, 8'h22, 8'hF0,
            13'h0100, 32'h33334444, 1, 0);
    run_req("len0", 1'b1, 3'b000, 3'd0, 2'd0, 10'd0, 16'h0a0b, 8'h23, 8'hFF,
            13'h0000, 32'h55556666, 1, 0);

    // Link loss while the header beat is waiting on tready
    wait_ready("lnk");
    drive_req(1'b0, 3'b000, 3'd0, 2'd0, 10'd1, 16'h1111, 8'h01, 8'h0F, 13'h0000);
    chk("lnk hdr up", 64'(tx_tvalid), 64'd1);
    lnk_up = 1'b0;
    @(negedge clk);
    chk_reset_outputs("lnk down");
    lnk_up = 1'b1;
    @(negedge clk);
    run_req("after lnk", 1'b0, 3'b001, 3'd2, 2'd1, 10'd1, 16'h2222, 8'h02, 8'h06,
            13'h0035, 32'h0, 0, 1);

    // Reset while waiting for read data
    wait_ready("rst");
    drive_req(1'b1, 3'b000, 3'd0, 2'd0, 10'd1, 16'h3333, 8'h03, 8'h0F, 13'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst mid wait");
    reset = 1'b1;
    rd_data_valid = 1'b1; rd_data = 32'hffffffff;
    @(negedge clk);
    rd_data_valid = 1'b0;
    chk("rst late data ignored", 64'(tx_tvalid), 64'd0);
    run_req("after rst", 1'b1, 3'b000, 3'd4, 2'd2, 10'd1, 16'h4444, 8'h04, 8'h0E,
            13'h007f, 32'h89abcdef, 3, 0);

    // Randomized requests
    for (int k = 0; k < 25; k++) begin
      logic [2:0] code;
      logic [9:0] len;
      case ($urandom_range(0, 2))
        0: code = 3'b000;
        1: code = 3'b001;
        default: code = 3'b100;
      endcase
      len = ($urandom_range(0, 2) == 0) ? 10'($urandom) : 10'd1;
      completer_id = 16'($urandom);
      run_req("rand", 1'($urandom), code, 3'($urandom), 2'($urandom), len,
              16'($urandom), 8'($urandom), 8'($urandom), 13'($urandom), $urandom,
              $urandom_range(0, 8), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
